// File: rtl/aes_shares_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : aes_shares_deserializer
// Purpose  : Assembles a 32-bit word stream into 128*d-bit key and plaintext
//            share buses for the masked AES top (share-major encoding).
//            Optional macro SHARES_KEY_REUSE_EN adds in_reuse_key (plaintext-
//            only frames that keep the previously loaded key).
// Revision : 1.0 - initial release
// ============================================================================
module aes_shares_deserializer #(
  parameter int d = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        in_word,
  input  logic               in_last,
  input  logic               in_valid,
`ifdef SHARES_KEY_REUSE_EN
  input  logic               in_reuse_key,
`endif
  output logic               in_ready,
  output logic [128*d-1:0]   out_shares_key,
  output logic [128*d-1:0]   out_shares_plaintext,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               frame_err
);

  localparam int CNT_W = $clog2(4*d);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(4*d-1);

  typedef enum logic [1:0] {
    LOAD_KEY = 2'd0,
    LOAD_PT  = 2'd1,
    FULL     = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [128*d-1:0]   key_q, key_d;
  logic [128*d-1:0]   pt_q, pt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_err_q, frame_err_d;

  logic               accept;
  logic               reuse_key;
  logic [CNT_W+4:0]   bit_idx;

`ifdef SHARES_KEY_REUSE_EN
  assign reuse_key = in_reuse_key;
`else
  assign reuse_key = 1'b0;
`endif

  assign accept  = in_valid & in_ready_q;
  // Word n of either half lands at bit 32*n, since share n/4 starts at 128*(n/4).
  assign bit_idx = {cnt_q, 5'b00000};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    pt_d        = pt_q;
    frame_err_d = 1'b0;

    case (state_q)
      LOAD_KEY: begin
        if (accept) begin
          if (reuse_key && (cnt_q == '0)) begin
            pt_d[bit_idx +: 32] = in_word;
            if (in_last) begin
              frame_err_d = 1'b1;
              cnt_d       = '0;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = LOAD_PT;
            end
          end else begin
            key_d[bit_idx +: 32] = in_word;
            if (in_last) begin
              frame_err_d = 1'b1;
              cnt_d       = '0;
            end else if (cnt_q == LAST_CNT) begin
              cnt_d   = '0;
              state_d = LOAD_PT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end

      LOAD_PT: begin
        if (accept) begin
          pt_d[bit_idx +: 32] = in_word;
          if (in_last != (cnt_q == LAST_CNT)) begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
            state_d     = LOAD_KEY;
          end else if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      FULL: begin
        if (out_ready) begin
          cnt_d   = '0;
          state_d = LOAD_KEY;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = LOAD_KEY;
      end
    endcase

    // Handshake flags follow the next state so they stay registered.
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d == FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_KEY;
      cnt_q       <= '0;
      key_q       <= '0;
      pt_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      pt_q        <= pt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign in_ready             = in_ready_q;
  assign out_valid            = out_valid_q;
  assign frame_err            = frame_err_q;
  assign out_shares_key       = key_q;
  assign out_shares_plaintext = pt_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_shares_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_shares_deserializer
// Purpose  : Directed self-checking bench for aes_shares_deserializer (d=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_shares_deserializer;

  localparam int D = 2;
  localparam int W = 128*D;
  localparam int NW = 8*D;

  logic          clk;
  logic          rst;
  logic [31:0]   in_word;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_shares_key;
  logic [W-1:0]  out_shares_plaintext;
  logic          out_valid;
  logic          out_ready;
  logic          frame_err;
`ifdef SHARES_KEY_REUSE_EN
  logic          in_reuse_key;
`endif

  int tests_run;
  int tests_failed;

  aes_shares_deserializer #(.d(D)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_word              (in_word),
    .in_last              (in_last),
    .in_valid             (in_valid),
`ifdef SHARES_KEY_REUSE_EN
    .in_reuse_key         (in_reuse_key),
`endif
    .in_ready             (in_ready),
    .out_shares_key       (out_shares_key),
    .out_shares_plaintext (out_shares_plaintext),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .frame_err            (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send_word(input logic [31:0] w, input logic last);
    int guard;
    guard    = 0;
    in_word  = w;
    in_last  = last;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] zero;
    zero = '0;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_word = '0; out_ready = 1'b0;
`ifdef SHARES_KEY_REUSE_EN
    in_reuse_key = 1'b0;
`endif
    repeat (3) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    tests_run++;
    if (out_shares_key !== zero || out_shares_plaintext !== zero) begin
      tests_failed++; $display("FAIL reset_buses: key=%h pt=%h, required 0", out_shares_key, out_shares_plaintext);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    logic [W-1:0] ek, ep;
    for (int i = 0; i < NW/2; i++) begin
      ek[32*i +: 32] = 32'(i);
      ep[32*i +: 32] = 32'(i + NW/2);
    end
    for (int i = 0; i < NW; i++) begin
      send_word(32'(i), i == NW-1);
      if (i == NW-2) begin
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid: got %b, required 0", out_valid); end
      end
    end
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_out_valid: got %b, required 1", out_valid); end
    tests_run++;
    if (out_shares_key[31:0] !== 32'h0 || out_shares_key[255:224] !== 32'h7) begin
      tests_failed++; $display("FAIL basic_key_words: lo=%h hi=%h, required 0 and 7", out_shares_key[31:0], out_shares_key[255:224]);
    end
    tests_run++;
    if (out_shares_plaintext[31:0] !== 32'h8 || out_shares_plaintext[255:224] !== 32'hF) begin
      tests_failed++; $display("FAIL basic_pt_words: lo=%h hi=%h, required 8 and f", out_shares_plaintext[31:0], out_shares_plaintext[255:224]);
    end
    tests_run++;
    if (out_shares_key !== ek || out_shares_plaintext !== ep) begin
      tests_failed++; $display("FAIL basic_full_buses: key=%h pt=%h, required key=%h pt=%h", out_shares_key, out_shares_plaintext, ek, ep);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] k0, p0;
    k0 = out_shares_key;
    p0 = out_shares_plaintext;
    in_valid = 1'b1; in_word = 32'hDEAD_BEEF; in_last = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        tests_failed++; $display("FAIL hold_flags cycle %0d: in_ready=%b out_valid=%b, required 0/1", c, in_ready, out_valid);
      end
      tests_run++;
      if (out_shares_key !== k0 || out_shares_plaintext !== p0) begin
        tests_failed++; $display("FAIL hold_buses cycle %0d: key=%h pt=%h, required %h %h", c, out_shares_key, out_shares_plaintext, k0, p0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL handshake_flags: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    tests_run++;
    if (out_shares_key !== k0 || out_shares_plaintext !== p0) begin
      tests_failed++; $display("FAIL handshake_buses: key=%h pt=%h, required %h %h", out_shares_key, out_shares_plaintext, k0, p0);
    end
  endtask

  task automatic test_frame_err();
    logic [W-1:0] ek, ep;
    for (int i = 0; i <= 5; i++) send_word(32'h50 + 32'(i), i == 5);
    tests_run++;
    if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL early_last_err: frame_err=%b out_valid=%b, required 1/0", frame_err, out_valid);
    end
    @(negedge clk);
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL err_pulse_width: got %b, required 0", frame_err); end
    // Missing in_last on the final word is also malformed.
    for (int i = 0; i < NW; i++) send_word(32'h60 + 32'(i), 1'b0);
    tests_run++;
    if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL missing_last_err: frame_err=%b out_valid=%b, required 1/0", frame_err, out_valid);
    end
    for (int i = 0; i < NW/2; i++) begin
      ek[32*i +: 32] = 32'h100 + 32'(i);
      ep[32*i +: 32] = 32'h100 + 32'(i + NW/2);
    end
    for (int i = 0; i < NW; i++) send_word(32'h100 + 32'(i), i == NW-1);
    tests_run++;
    if (out_valid !== 1'b1 || frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL recover_flags: out_valid=%b frame_err=%b, required 1/0", out_valid, frame_err);
    end
    tests_run++;
    if (out_shares_key !== ek || out_shares_plaintext !== ep) begin
      tests_failed++; $display("FAIL recover_buses: key=%h pt=%h, required key=%h pt=%h", out_shares_key, out_shares_plaintext, ek, ep);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] ek, ep, zero;
    zero = '0;
    for (int i = 0; i <= 9; i++) send_word(32'h200 + 32'(i), 1'b0);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL async_rst_flags: in_ready=%b out_valid=%b, required 0/0", in_ready, out_valid);
    end
    tests_run++;
    if (out_shares_key !== zero || out_shares_plaintext !== zero) begin
      tests_failed++; $display("FAIL async_rst_buses: key=%h pt=%h, required 0", out_shares_key, out_shares_plaintext);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NW/2; i++) begin
      ek[32*i +: 32] = 32'h300 + 32'(i);
      ep[32*i +: 32] = 32'h300 + 32'(i + NW/2);
    end
    for (int i = 0; i < NW-1; i++) send_word(32'h300 + 32'(i), 1'b0);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL post_rst_partial: out_valid=%b, required 0", out_valid); end
    send_word(32'h300 + 32'(NW-1), 1'b1);
    tests_run++;
    if (out_valid !== 1'b1 || out_shares_key !== ek || out_shares_plaintext !== ep) begin
      tests_failed++; $display("FAIL post_rst_frame: out_valid=%b key=%h pt=%h, required 1 key=%h pt=%h", out_valid, out_shares_key, out_shares_plaintext, ek, ep);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_random_traffic();
    logic [W-1:0] ek, ep;
    logic [31:0]  w;
    int guard;
    bit done;
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < NW; i++) begin
        w = $urandom;
        if (i < NW/2) ek[32*i +: 32] = w;
        else          ep[32*(i-NW/2) +: 32] = w;
        if ($urandom_range(1) == 1) @(negedge clk);
        send_word(w, i == NW-1);
      end
      guard = 0;
      done  = 1'b0;
      while (!done && guard < 64) begin
        out_ready = ($urandom_range(1) == 1);
        if (out_valid === 1'b1 && out_ready) begin
          tests_run++;
          if (out_shares_key !== ek || out_shares_plaintext !== ep) begin
            tests_failed++; $display("FAIL random_frame %0d: key=%h pt=%h, required key=%h pt=%h", f, out_shares_key, out_shares_plaintext, ek, ep);
          end
          done = 1'b1;
        end
        @(negedge clk);
        guard++;
      end
      out_ready = 1'b0;
      if (!done) begin
        tests_run++; tests_failed++;
        $display("FAIL random_timeout %0d: out_valid=%b, required 1", f, out_valid);
      end
    end
  endtask

`ifdef SHARES_KEY_REUSE_EN
  task automatic test_key_reuse();
    logic [W-1:0] ek, ep;
    for (int i = 0; i < NW/2; i++) ek[32*i +: 32] = 32'h400 + 32'(i);
    for (int i = 0; i < NW; i++) send_word(32'h400 + 32'(i), i == NW-1);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    for (int i = 0; i < NW/2; i++) begin
      ep[32*i +: 32] = 32'h500 + 32'(i);
      in_reuse_key = (i == 0);
      send_word(32'h500 + 32'(i), i == NW/2-1);
      in_reuse_key = 1'b0;
    end
    tests_run++;
    if (out_valid !== 1'b1 || frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL reuse_flags: out_valid=%b frame_err=%b, required 1/0", out_valid, frame_err);
    end
    tests_run++;
    if (out_shares_key !== ek || out_shares_plaintext !== ep) begin
      tests_failed++; $display("FAIL reuse_buses: key=%h pt=%h, required key=%h pt=%h", out_shares_key, out_shares_plaintext, ek, ep);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_frame_err();
    test_async_reset();
    test_random_traffic();
`ifdef SHARES_KEY_REUSE_EN
    test_key_reuse();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
